// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-wide memory port.
// Steers store bytes onto lanes, extends loads, and splits lane-crossing accesses into two beats.
module lsu_ctrl #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              resp_valid,
    output logic [XLEN-1:0]   load_data,
    output logic              fault,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state, state_nxt;

    logic [4:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   sdata_q, rdata0_q, rdata1_q;
    logic              fault_q, cross_q;

    logic req_mem, req_size_ok, req_cross, req_fault;
    assign req_mem     = mem_op[4] ^ mem_op[3];
    assign req_size_ok = (mem_op[1:0] != 2'b11) || (XLEN == 64);
    assign req_cross   = (int'(addr[OFS_W-1:0]) + (1 << mem_op[1:0])) > NB;
    assign req_fault   = !req_size_ok || (req_cross && !MISALIGN_SPLIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            fault_q  <= 1'b0;
            cross_q  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q     <= mem_op;
                addr_q   <= addr;
                sdata_q  <= store_data;
                fault_q  <= req_fault;
                cross_q  <= req_cross;
                // Cleared so an aligned load shifts in zeros from the unused upper beat
                rdata0_q <= '0;
                rdata1_q <= '0;
            end
            if (state == BEAT0 && mem_ack) rdata0_q <= mem_rdata;
            if (state == BEAT1 && mem_ack) rdata1_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && req_mem) state_nxt = req_fault ? RESP : BEAT0;
            BEAT0:   if (mem_ack) state_nxt = cross_q ? BEAT1 : RESP;
            BEAT1:   if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [OFS_W-1:0]  ofs;
    logic [3:0]        sz;
    logic              is_wr, sign;
    logic [2*NB-1:0]   lane_mask, wen_full;
    logic [2*XLEN-1:0] wdata_full, rdata_sh;
    logic [ADDR_W-1:0] base;
    logic [XLEN-1:0]   ext;

    assign ofs   = addr_q[OFS_W-1:0];
    assign sz    = 4'd1 << op_q[1:0];
    assign is_wr = (op_q[4:3] == 2'b10);
    assign base  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) lane_mask[i] = (i < int'(sz));
    end

    // Upper halves of the double-width shifts are exactly the second-beat lanes/data
    assign wen_full   = lane_mask << ofs;
    assign wdata_full = {{XLEN{1'b0}}, sdata_q} << {ofs, 3'b000};
    assign rdata_sh   = {rdata1_q, rdata0_q} >> {ofs, 3'b000};

    always_comb begin
        case (op_q[1:0])
            2'b00:   sign = rdata_sh[7];
            2'b01:   sign = rdata_sh[15];
            2'b10:   sign = rdata_sh[31];
            default: sign = rdata_sh[63];
        endcase
        sign = sign & !op_q[2];
        ext  = '0;
        for (int b = 0; b < NB; b++)
            ext[8*b +: 8] = (b < int'(sz)) ? rdata_sh[8*b +: 8] : {8{sign}};
    end

    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_wen    = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        fault      = 1'b0;
        load_data  = '0;
        case (state)
            BEAT0: begin
                mem_req  = 1'b1;
                mem_addr = base;
                if (is_wr) begin
                    mem_wen   = wen_full[NB-1:0];
                    mem_wdata = wdata_full[XLEN-1:0];
                end
            end
            BEAT1: begin
                mem_req  = 1'b1;
                mem_addr = base + ADDR_W'(NB);
                if (is_wr) begin
                    mem_wen   = wen_full[2*NB-1:NB];
                    mem_wdata = wdata_full[2*XLEN-1:XLEN];
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                fault      = fault_q;
                if (!fault_q && !is_wr) load_data = ext;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed ops queue expected beats and responses,
// a memory responder and a response monitor check them independently.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid, req_ready, resp_valid, fault, mem_req;
    logic [4:0]  mem_op;
    logic [31:0] addr, store_data, load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        req_valid_ns, req_ready_ns, resp_valid_ns, fault_ns, mem_req_ns;
    logic [31:0] load_data_ns, mem_addr_ns, mem_wdata_ns;
    logic [3:0]  mem_wen_ns;
    logic        mem_ack_ns = 1'b0;
    logic [31:0] mem_rdata_ns = '0;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .load_data(load_data), .fault(fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
        .mem_op(mem_op), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid_ns), .load_data(load_data_ns), .fault(fault_ns),
        .mem_req(mem_req_ns), .mem_addr(mem_addr_ns), .mem_wen(mem_wen_ns), .mem_wdata(mem_wdata_ns),
        .mem_ack(mem_ack_ns), .mem_rdata(mem_rdata_ns)
    );

    typedef struct {
        logic [31:0] ld;
        logic        flt;
        int          at;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  wen;
        logic [31:0] wd;
        int          waits;
        logic [31:0] rd;
    } beat_t;

    resp_t rq[$];
    beat_t bq[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: pops one expected beat per request, checks it every cycle it is held,
    // and acks after the programmed number of wait cycles.
    beat_t cur;
    bit    active = 1'b0;
    int    waited = 0;
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            active  = 1'b0;
        end else begin
            if (!active) begin
                if (bq.size() == 0) begin
                    check("unexpected_beat", mem_req, 0);
                    mem_ack = 1'b0;
                end else begin
                    cur    = bq.pop_front();
                    active = 1'b1;
                    waited = 0;
                end
            end
            if (active) begin
                check("mem_addr", mem_addr, cur.a);
                check("mem_wen", mem_wen, cur.wen);
                check("mem_wdata", mem_wdata, cur.wd);
                if (waited == cur.waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rd;
                    active    = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    waited++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            if (rq.size() == 0) check("unexpected_resp", resp_valid, 0);
            else begin
                resp_t e;
                e = rq.pop_front();
                check("load_data", load_data, e.ld);
                check("fault", fault, e.flt);
                check("resp_cycle", cyc, e.at);
            end
        end
    end

    // The no-split instance only ever sees faulting ops, so its port must stay quiet
    always @(negedge clk) begin
        if (!rst) begin
            check("ns_mem_req", mem_req_ns, 0);
            check("ns_mem_addr", mem_addr_ns, 0);
            check("ns_mem_wen_wdata", {mem_wen_ns, mem_wdata_ns}, 0);
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd);
        beat_t b;
        b = '{a: a, wen: wen, wd: wd, waits: waits, rd: rd};
        bq.push_back(b);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] ld, input logic flt, input int lat, input bit exp_resp);
        int    n = 0;
        resp_t r;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
        if (exp_resp) begin
            r = '{ld: ld, flt: flt, at: cyc + lat};
            rq.push_back(r);
        end
        req_valid  = 1'b1;
        mem_op     = op;
        addr       = a;
        store_data = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue_ns(input logic [4:0] op, input logic [31:0] a);
        check("ns_req_ready", req_ready_ns, 1);
        req_valid_ns = 1'b1;
        mem_op       = op;
        addr         = a;
        store_data   = 32'h5555_5555;
        @(negedge clk);
        req_valid_ns = 1'b0;
        check("ns_resp_valid", resp_valid_ns, 1);
        check("ns_fault", fault_ns, 1);
        check("ns_load_data", load_data_ns, 0);
        @(negedge clk);
        check("ns_resp_pulse", resp_valid_ns, 0);
        check("ns_ready_again", req_ready_ns, 1);
    endtask

    initial begin
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
        mem_op       = '0;
        addr         = '0;
        store_data   = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_load_data", load_data, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // byte store, lane 3
        push_beat(32'h1000, 4'b1000, 32'hAB00_0000, 0, 32'h0);
        issue(5'b10_0_00, 32'h1003, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b1);
        // signed / unsigned half loads from upper half
        push_beat(32'h2000, 4'b0000, 32'h0, 0, 32'h8001_1234);
        issue(5'b01_0_01, 32'h2002, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1'b1);
        push_beat(32'h2000, 4'b0000, 32'h0, 0, 32'h8001_1234);
        issue(5'b01_1_01, 32'h2002, 32'h0, 32'h0000_8001, 1'b0, 2, 1'b1);
        // split word store
        push_beat(32'h3000, 4'b1000, 32'h4400_0000, 0, 32'h0);
        push_beat(32'h3004, 4'b0111, 32'h0011_2233, 0, 32'h0);
        issue(5'b10_0_10, 32'h3003, 32'h1122_3344, 32'h0, 1'b0, 3, 1'b1);
        // split word load with two wait states per beat
        push_beat(32'h4000, 4'b0000, 32'h0, 2, 32'hDDCC_0000);
        push_beat(32'h4004, 4'b0000, 32'h0, 2, 32'h0000_FFEE);
        issue(5'b01_0_10, 32'h4002, 32'h0, 32'hFFEE_DDCC, 1'b0, 7, 1'b1);
        // dword with XLEN=32 faults without touching memory
        issue(5'b01_0_11, 32'h6000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        // no-op classes are dropped
        issue(5'b00_0_10, 32'h7000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        check("noop_ready", req_ready, 1);
        check("noop_mem_req", mem_req, 0);
        issue(5'b11_0_10, 32'h7004, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        check("noop11_ready", req_ready, 1);
        // byte loads: signed lane 1, unsigned lane 3
        push_beat(32'h1000, 4'b0000, 32'h0, 0, 32'h1234_80FF);
        issue(5'b01_0_00, 32'h1001, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
        push_beat(32'h1000, 4'b0000, 32'h0, 1, 32'hF000_0000);
        issue(5'b01_1_00, 32'h1003, 32'h0, 32'h0000_00F0, 1'b0, 3, 1'b1);
        // half store upper lanes
        push_beat(32'h8000, 4'b1100, 32'hBEEF_0000, 0, 32'h0);
        issue(5'b10_0_01, 32'h8002, 32'h0000_BEEF, 32'h0, 1'b0, 2, 1'b1);
        // split signed half load
        push_beat(32'h9000, 4'b0000, 32'h0, 0, 32'h7F00_0000);
        push_beat(32'h9004, 4'b0000, 32'h0, 0, 32'h0000_00A5);
        issue(5'b01_0_01, 32'h9003, 32'h0, 32'hFFFF_A57F, 1'b0, 3, 1'b1);
        // split store wrapping past the top of the address space
        push_beat(32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000, 0, 32'h0);
        push_beat(32'h0000_0000, 4'b0011, 32'h0000_CAFE, 0, 32'h0);
        issue(5'b10_0_10, 32'hFFFF_FFFE, 32'hCAFE_BABE, 32'h0, 1'b0, 3, 1'b1);

        // reset while BEAT0 is stalled
        push_beat(32'hB000, 4'b0000, 32'h0, 10, 32'hDEAD_BEEF);
        issue(5'b01_0_10, 32'hB000, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        rst = 1'b0;
        check("midrst_beat_q", bq.size(), 0);
        push_beat(32'hA000, 4'b0000, 32'h0, 1, 32'h1234_5678);
        issue(5'b01_0_10, 32'hA000, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b1);

        // no-split instance: crossing word store and dword both fault at T+1
        issue_ns(5'b10_0_10, 32'h5001);
        issue_ns(5'b01_0_11, 32'h5000);
        issue_ns(5'b01_0_01, 32'h5003);

        begin
            int n = 0;
            while ((rq.size() != 0 || bq.size() != 0 || !req_ready) && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain_resp_q", rq.size(), 0);
        check("drain_beat_q", bq.size(), 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Parametrised load/store controller between the pipeline MEM stage and a word-wide data memory port. It accepts one memory op per handshake and generates byte-lane write enables and lane-shifted write data. On loads it extracts and sign- or zero-extends the requested bytes. Misaligned accesses are split into two memory beats, or rejected with a fault, depending on configuration. Memory may stall with wait states via an ack signal.

Parameters:
XLEN, 32, data/port width in bits (32 or 64); NB = XLEN/8 byte lanes, OFS_W = log2(NB)
ADDR_W, 32, address width
MISALIGN_SPLIT, 1, 1 = split lane-crossing accesses into two beats; 0 = reject them with fault

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  op request from pipeline
req_ready  out  1  controller can accept a request
mem_op  in  5  [4:3] class: 01 read, 10 write, 00/11 no-op; [2] 1 = unsigned load; [1:0] size: 00 byte, 01 half, 10 word, 11 dword
addr  in  ADDR_W  byte address
store_data  in  XLEN  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
load_data  out  XLEN  extended load result; 0 for stores and faults
fault  out  1  qualifies resp_valid: access is misaligned (split disabled) or has an illegal size
mem_req  out  1  memory beat request
mem_addr  out  ADDR_W  NB-aligned beat address
mem_wen  out  NB  byte-lane write enables; all 0 for reads
mem_wdata  out  XLEN  lane-shifted write data
mem_ack  in  1  beat complete; mem_rdata valid in the same cycle
mem_rdata  in  XLEN  read data

Behaviour:
- Reset values: req_ready=1, resp_valid=0, fault=0, load_data=0, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0. State returns to IDLE.
- Size in bytes: SZ = 1, 2, 4 or 8. Size 11 with XLEN=32 is illegal. Offset: o = addr[OFS_W-1:0]. An access is crossing when o+SZ > NB.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid, register op, addr and store_data.
  - Class 00 or 11: dropped. No memory activity, no response.
  - Illegal size, or crossing with MISALIGN_SPLIT=0: go to RESP with fault=1.
  - Otherwise: go to BEAT0.
- req_ready=0 in every state except IDLE.
- BEAT0: mem_req=1; mem_addr = addr with the low OFS_W bits cleared.
  - Writes: mem_wen = ((1<<SZ)-1) << o, truncated to NB bits; mem_wdata = store_data << 8*o.
  - mem_req, mem_addr, mem_wen and mem_wdata are held stable until mem_ack.
  - On mem_ack: capture mem_rdata. If crossing, go to BEAT1; else go to RESP.
- BEAT1: mem_addr = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - Writes: mem_wen = ((1<<SZ)-1) >> (NB-o); mem_wdata = store_data >> 8*(NB-o).
  - On mem_ack: capture mem_rdata, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted in the cycle after RESP.
  - Loads: form the 2*XLEN value {beat1, beat0} and shift right by 8*o. Take the low SZ bytes, then zero-extend if mem_op[2]=1, else sign-extend from the top byte of the access.
  - Stores: load_data=0.
  - fault=1 only in a faulting RESP. No memory beat is ever issued for a faulting op.
- Latency with zero-wait memory (ack in the same cycle as req):
  - Accept at T, mem_req at T+1, resp_valid at T+2 (aligned) or T+3 (split).
  - Each wait cycle adds one. A fault responds at T+1.
- mem_ack outside BEAT0/BEAT1 is ignored.
- Reset at any point, including mid-BEAT: the next cycle shows mem_req=0 and req_ready=1. The in-flight op is discarded with no resp_valid. Memory must tolerate an abandoned request.
- mem_req is never asserted in two different beats in the same cycle. A store's two beats are never merged.

Test Plan:
- Byte store, addr 0x1003, data 0x000000AB, zero-wait -> mem_addr 0x1000, mem_wen 4'b1000, mem_wdata 0xAB000000; resp_valid at T+2, load_data 0, fault 0.
- Signed half load, addr 0x2002, mem_rdata 0x8001_1234 -> load_data 0xFFFF8001. Same op with mem_op[2]=1 -> 0x00008001.
- Split word store, addr 0x3003, data 0x11223344 -> beat0 0x3000 wen 1000 wdata 0x44000000; beat1 0x3004 wen 0111 wdata 0x00112233; one resp_valid at T+3.
- Split word load, addr 0x4002, beat0 rdata 0xDDCC0000, beat1 rdata 0x0000FFEE, mem_ack delayed 2 cycles per beat -> load_data 0xFFEEDDCC; resp_valid at T+7; request outputs stable during waits.
- MISALIGN_SPLIT=0: word store at 0x5001 -> no mem_req; resp_valid with fault=1 at T+1. Dword op with XLEN=32 -> fault=1.
- rst asserted during BEAT0 while mem_ack=0 -> next cycle mem_req=0, req_ready=1; no resp_valid; a following aligned load completes normally.
